// File: rtl/psum_requant_pkg.sv
// Shared types and constants for the psum requantizer: FSM states,
// accumulator saturation bounds and the activation clip ceiling.
package psum_requant_pkg;

    localparam int def_bw      = 4;
    localparam int def_psum_bw = 16;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_accum = 2'd1,
        st_flush = 2'd2
    } state_t;

    localparam logic signed [def_psum_bw-1:0] sat_max = {1'b0, {(def_psum_bw-1){1'b1}}};
    localparam logic signed [def_psum_bw-1:0] sat_min = {1'b1, {(def_psum_bw-1){1'b0}}};
    localparam logic [def_bw-1:0]             clip_max = {def_bw{1'b1}};

endpackage

// File: rtl/requant_lane.sv
// One lane: saturating accumulate, then ReLU, arithmetic shift and clip.
// Purely combinational; no handshake of its own.
module requant_lane
    import psum_requant_pkg::*;
#(
    parameter int bw      = def_bw,
    parameter int psum_bw = def_psum_bw
) (
    input  logic signed [psum_bw-1:0] acc,
    input  logic signed [psum_bw-1:0] psum,
    input  logic                      add_en,
    input  logic [3:0]                shift,
    output logic signed [psum_bw-1:0] sum_sat,
    output logic [bw-1:0]             act
);

    localparam logic signed [psum_bw:0]   sum_hi    = {sat_max[psum_bw-1], sat_max};
    localparam logic signed [psum_bw:0]   sum_lo    = {sat_min[psum_bw-1], sat_min};
    localparam logic signed [psum_bw-1:0] clip_wide = {{(psum_bw-bw){1'b0}}, clip_max};

    logic signed [psum_bw:0]   sum_wide;
    logic signed [psum_bw-1:0] shifted;

    always_comb begin
        sum_wide = {psum[psum_bw-1], psum};
        if (add_en) begin
            sum_wide = {acc[psum_bw-1], acc} + {psum[psum_bw-1], psum};
        end

        if (sum_wide > sum_hi) begin
            sum_sat = sat_max;
        end else if (sum_wide < sum_lo) begin
            sum_sat = sat_min;
        end else begin
            sum_sat = sum_wide[psum_bw-1:0];
        end

        // Negative sums are zeroed before the shift ever matters.
        shifted = sum_sat >>> shift;
        if (sum_sat[psum_bw-1]) begin
            act = '0;
        end else if (shifted > clip_wide) begin
            act = clip_max;
        end else begin
            act = shifted[bw-1:0];
        end
    end

endmodule

// File: rtl/psum_requant.sv
// Multi-pass column psum accumulator with ReLU/shift/clip requant to bw-bit activations.
// Latency: final-pass beat accepted -> out_valid the next cycle; one beat/cycle sustained.
// Backpressure: single output register; in_ready drops on the final pass while out is stalled.
module psum_requant
    import psum_requant_pkg::*;
#(
    parameter int bw      = def_bw,
    parameter int psum_bw = def_psum_bw,
    parameter int col     = 8,
    parameter int depth   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                cfg_num_pass,
    input  logic [3:0]                cfg_shift,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [col*psum_bw-1:0]    in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [col*bw-1:0]         out_act,
    output logic                      busy,
    output logic                      done
);

    localparam int ptr_w = $clog2(depth);

    state_t             state;
    logic [ptr_w-1:0]   row_ptr;
    logic [3:0]         pass_cnt;
    logic [3:0]         num_pass;
    logic [3:0]         shift_q;

    logic signed [psum_bw-1:0] acc_mem  [depth][col];
    logic signed [psum_bw-1:0] lane_sum [col];
    logic [col*bw-1:0]         lane_act;

    logic final_pass;
    logic last_row;
    logic accept;
    logic drain;

    assign final_pass = (pass_cnt == num_pass - 4'd1);
    assign last_row   = (row_ptr == ptr_w'(depth - 1));
    assign drain      = out_valid && out_ready;
    // Final pass may only write the output register when it is empty or emptying now.
    assign in_ready   = (state == st_accum) && (!final_pass || !out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != st_idle);
    assign done       = (state == st_flush) && drain;

    for (genvar k = 0; k < col; k++) begin : g_lane
        requant_lane #(
            .bw      (bw),
            .psum_bw (psum_bw)
        ) u_lane (
            .acc     (acc_mem[row_ptr][k]),
            .psum    (in_psum[k*psum_bw +: psum_bw]),
            .add_en  (pass_cnt != 4'd0),
            .shift   (shift_q),
            .sum_sat (lane_sum[k]),
            .act     (lane_act[k*bw +: bw])
        );
    end

    // Storage is left unreset: pass 0 always overwrites an entry before it is read.
    always_ff @(posedge clk) begin
        if (accept && !final_pass) begin
            for (int k = 0; k < col; k++) begin
                acc_mem[row_ptr][k] <= lane_sum[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= st_idle;
            row_ptr   <= '0;
            pass_cnt  <= '0;
            num_pass  <= 4'd1;
            shift_q   <= '0;
            out_valid <= 1'b0;
            out_act   <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        state    <= st_accum;
                        num_pass <= (cfg_num_pass == 4'd0) ? 4'd1 : cfg_num_pass;
                        shift_q  <= cfg_shift;
                        row_ptr  <= '0;
                        pass_cnt <= '0;
                    end
                end
                st_accum: begin
                    if (accept) begin
                        row_ptr <= last_row ? '0 : row_ptr + ptr_w'(1);
                        if (last_row) begin
                            if (final_pass) begin
                                state <= st_flush;
                            end else begin
                                pass_cnt <= pass_cnt + 4'd1;
                            end
                        end
                    end
                end
                st_flush: begin
                    if (drain) begin
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase

            if (accept && final_pass) begin
                out_valid <= 1'b1;
                out_act   <= lane_act;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
